// File: rtl/tmp_seq_pkg.sv
// Shared types and switch patterns for the temperature-sensor sequencer.
package tmp_seq_pkg;

    // Sequencer state encoding
    typedef logic [2:0] state_t;

    localparam state_t StIdle   = 3'd0;
    localparam state_t StPre    = 3'd1;
    localparam state_t StBlank  = 3'd2;
    localparam state_t StSetup  = 3'd3;
    localparam state_t StDiode  = 3'd4;
    localparam state_t StBig    = 3'd5;
    localparam state_t StCharge = 3'd6;
    localparam state_t StOut    = 3'd7;

    // Analog switch vector, MSB first: pi1 pi2 pii1 pii2 pa pb pc pd
    typedef struct packed {
        logic pi1;
        logic pi2;
        logic pii1;
        logic pii2;
        logic pa;
        logic pb;
        logic pc;
        logic pd;
    } sw_t;

    // Rest pattern: output caps shorted (idle, precharge, output)
    localparam sw_t SwRest  = sw_t'(8'b0000_0111);
    // All switches open (blanking between phases)
    localparam sw_t SwOff   = sw_t'(8'b0000_0000);
    // Big-diode phase (setup and conversion)
    localparam sw_t SwBig   = sw_t'(8'b1100_0000);
    // Diode phase
    localparam sw_t SwDiode = sw_t'(8'b0011_0000);
    // Charge phase, decision 1 routes to pb
    localparam sw_t SwChgHi = sw_t'(8'b0000_1100);
    // Charge phase, decision 0 routes to pc
    localparam sw_t SwChgLo = sw_t'(8'b0000_1010);

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tmp_phase_timer.sv
// Shared phase down-counter: loaded with (length-1) on phase entry, flags the final cycle.
module tmp_phase_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Load on phase entry, otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/tmp_seq_ctrl.sv
// Switched-capacitor temperature sensor sequencer: bias setup, NCONV conversions, result.
module tmp_seq_ctrl
    import tmp_seq_pkg::*;
#(
    parameter  int unsigned PRE_CYC    = 11,
    parameter  int unsigned SETUP_CYC  = 4,
    parameter  int unsigned SETUP_ITER = 8,
    parameter  int unsigned DIODE_CYC  = 9,
    parameter  int unsigned BIG_CYC    = 12,
    parameter  int unsigned CHG_CYC    = 6,
    parameter  int unsigned NCONV      = 16,
    localparam int unsigned RES_W      = $clog2(NCONV + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             cont_mode_i,
    input  logic             cmp_i,
    output logic             pi1_o,
    output logic             pi2_o,
    output logic             pii1_o,
    output logic             pii2_o,
    output logic             pa_o,
    output logic             pb_o,
    output logic             pc_o,
    output logic             pd_o,
    output logic             cmp_p1_o,
    output logic             cmp_p2_o,
    output logic             src_n_o,
    output logic             snk_o,
    output logic             pre_chrg_o,
    output logic             setup_bias_o,
    output logic             busy_o,
    output logic [RES_W-1:0] result_o,
    output logic             valid_o
);

    localparam int unsigned MaxLen = max_u(max_u(max_u(PRE_CYC, SETUP_CYC), max_u(DIODE_CYC,
                                           BIG_CYC)), CHG_CYC);
    localparam int unsigned TW     = $clog2(MaxLen + 1);
    localparam int unsigned SetW   = $clog2(SETUP_ITER + 1);

    state_t            state_q, state_d;
    state_t            ret_q, ret_d;
    logic [SetW-1:0]   setup_cnt_q, setup_cnt_d;
    logic [RES_W-1:0]  conv_cnt_q, conv_cnt_d;
    logic [RES_W-1:0]  acc_q, acc_d;
    logic [RES_W-1:0]  result_q, result_d;
    logic              bit_q, bit_d;
    logic              sb_q, sb_d;
    logic              src_pulse, snk_pulse;

    sw_t               sw_q, sw_d;
    logic              cp1_q, cp1_d, cp2_q;
    logic              src_n_q, snk_q, pre_q, busy_q, valid_q;

    logic              tmr_load, tmr_last;
    logic [TW-1:0]     tmr_val;
    int unsigned       phase_len;

    tmp_phase_timer #(
        .WIDTH (TW)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .last_o     (tmr_last)
    );

    // Next state, counters, accumulator and pump pulse decisions
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        setup_cnt_d = setup_cnt_q;
        conv_cnt_d  = conv_cnt_q;
        acc_d       = acc_q;
        result_d    = result_q;
        bit_d       = bit_q;
        sb_d        = sb_q;
        src_pulse   = 1'b0;
        snk_pulse   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StPre;
                    sb_d        = 1'b1;
                    setup_cnt_d = '0;
                    conv_cnt_d  = '0;
                    acc_d       = '0;
                end
            end
            StPre: begin
                if (tmr_last) begin
                    state_d = StBlank;
                    ret_d   = StSetup;
                end
            end
            StBlank: begin
                state_d = ret_q;
                // Conversion bias pump fires as CHARGE is entered
                if (ret_q == StCharge) begin
                    src_pulse = bit_q;
                    snk_pulse = ~bit_q;
                end
            end
            StSetup: begin
                if (tmr_last) begin
                    state_d = StBlank;
                    ret_d   = StSetup;
                    if (cmp_i) begin
                        src_pulse = 1'b1;
                    end else begin
                        snk_pulse = 1'b1;
                        if (setup_cnt_q == SetW'(SETUP_ITER - 1)) begin
                            sb_d        = 1'b0;
                            ret_d       = StDiode;
                            setup_cnt_d = '0;
                        end else begin
                            setup_cnt_d = setup_cnt_q + 1'b1;
                        end
                    end
                end
            end
            StDiode: begin
                if (tmr_last) begin
                    state_d = StBlank;
                    ret_d   = StBig;
                end
            end
            StBig: begin
                if (tmr_last) begin
                    state_d = StBlank;
                    ret_d   = StCharge;
                    bit_d   = cmp_i;
                    if (cmp_i && (acc_q != RES_W'(NCONV))) begin
                        acc_d = acc_q + 1'b1;
                    end
                end
            end
            StCharge: begin
                if (tmr_last) begin
                    if (conv_cnt_q == RES_W'(NCONV - 1)) begin
                        state_d    = StOut;
                        conv_cnt_d = '0;
                        result_d   = acc_q;
                        acc_d      = '0;
                    end else begin
                        state_d    = StBlank;
                        ret_d      = StDiode;
                        conv_cnt_d = conv_cnt_q + 1'b1;
                    end
                end
            end
            StOut: begin
                if (cont_mode_i) begin
                    state_d = StBlank;
                    ret_d   = StDiode;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Phase length of the state being entered; timer reloads on every state change
    always_comb begin
        phase_len = 1;
        case (state_d)
            StPre:    phase_len = PRE_CYC;
            StSetup:  phase_len = SETUP_CYC;
            StDiode:  phase_len = DIODE_CYC;
            StBig:    phase_len = BIG_CYC;
            StCharge: phase_len = CHG_CYC;
            default:  phase_len = 1;
        endcase
        tmr_load = (state_d != state_q);
        tmr_val  = TW'(phase_len - 1);
    end

    // Switch pattern and chop phase for the upcoming state, registered below
    always_comb begin
        sw_d = SwRest;
        case (state_d)
            StIdle, StPre, StOut: sw_d = SwRest;
            StBlank:              sw_d = SwOff;
            StSetup, StBig:       sw_d = SwBig;
            StDiode:              sw_d = SwDiode;
            StCharge:             sw_d = bit_d ? SwChgHi : SwChgLo;
            default:              sw_d = SwRest;
        endcase
        cp1_d = (state_d == StBlank) ? ~cp1_q : cp1_q;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ret_q       <= StIdle;
            setup_cnt_q <= '0;
            conv_cnt_q  <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            bit_q       <= 1'b0;
            sb_q        <= 1'b0;
            sw_q        <= SwRest;
            cp1_q       <= 1'b0;
            cp2_q       <= 1'b1;
            src_n_q     <= 1'b1;
            snk_q       <= 1'b0;
            pre_q       <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            setup_cnt_q <= setup_cnt_d;
            conv_cnt_q  <= conv_cnt_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            bit_q       <= bit_d;
            sb_q        <= sb_d;
            sw_q        <= sw_d;
            cp1_q       <= cp1_d;
            cp2_q       <= ~cp1_d;
            src_n_q     <= ~src_pulse;
            snk_q       <= snk_pulse;
            pre_q       <= (state_d == StPre);
            busy_q      <= (state_d != StIdle);
            valid_q     <= (state_d == StOut);
        end
    end

    assign pi1_o        = sw_q.pi1;
    assign pi2_o        = sw_q.pi2;
    assign pii1_o       = sw_q.pii1;
    assign pii2_o       = sw_q.pii2;
    assign pa_o         = sw_q.pa;
    assign pb_o         = sw_q.pb;
    assign pc_o         = sw_q.pc;
    assign pd_o         = sw_q.pd;
    assign cmp_p1_o     = cp1_q;
    assign cmp_p2_o     = cp2_q;
    assign src_n_o      = src_n_q;
    assign snk_o        = snk_q;
    assign pre_chrg_o   = pre_q;
    assign setup_bias_o = sb_q;
    assign busy_o       = busy_q;
    assign result_o     = result_q;
    assign valid_o      = valid_q;

endmodule

// File: tb/tb_tmp_seq_ctrl.sv
// Self-checking bench: expected per-cycle waveform built from the phase schedule.
module tb_tmp_seq_ctrl;

    localparam int unsigned PRE   = 11;
    localparam int unsigned SCYC  = 4;
    localparam int unsigned SITER = 8;
    localparam int unsigned DCYC  = 9;
    localparam int unsigned BCYC  = 12;
    localparam int unsigned CCYC  = 6;
    localparam int unsigned NC    = 16;
    localparam int unsigned RW    = $clog2(NC + 1);
    localparam int PERIOD = NC * (DCYC + BCYC + CCYC + 3) + 1;

    localparam int PH_IDLE = 0, PH_PRE = 1, PH_BLANK = 2, PH_SETUP = 3;
    localparam int PH_DIODE = 4, PH_BIG = 5, PH_CHG = 6, PH_OUT = 7;

    // {pi1 pi2 pii1 pii2 pa pb pc pd}
    localparam logic [7:0] SW_REST = 8'b0000_0111;
    localparam logic [7:0] SW_OFF  = 8'b0000_0000;
    localparam logic [7:0] SW_PI   = 8'b1100_0000;
    localparam logic [7:0] SW_PII  = 8'b0011_0000;
    localparam logic [7:0] SW_HI   = 8'b0000_1100;
    localparam logic [7:0] SW_LO   = 8'b0000_1010;

    typedef struct packed {
        logic [7:0]    sw;
        logic          cp1;
        logic          cp2;
        logic          src_n;
        logic          snk;
        logic          pre;
        logic          sb;
        logic          busy;
        logic          valid;
        logic [RW-1:0] res;
    } obs_t;

    typedef struct {
        obs_t o;
        logic cmp;
        logic cont;
        logic start;
        int   ph;
    } step_t;

    logic clk = 1'b0;
    logic reset, start_i, cont_mode_i, cmp_i;
    logic pi1_o, pi2_o, pii1_o, pii2_o, pa_o, pb_o, pc_o, pd_o;
    logic cmp_p1_o, cmp_p2_o, src_n_o, snk_o, pre_chrg_o, setup_bias_o, busy_o, valid_o;
    logic [RW-1:0] result_o;

    int total = 0;
    int bad   = 0;
    step_t tr[$];
    int valid_at[$];
    int npre;
    int rnd_start;
    logic aborted;
    logic m_cp1, m_sb, pend_src, pend_snk, pend_fall;
    logic [RW-1:0] m_res;

    tmp_seq_ctrl #(
        .PRE_CYC    (PRE),
        .SETUP_CYC  (SCYC),
        .SETUP_ITER (SITER),
        .DIODE_CYC  (DCYC),
        .BIG_CYC    (BCYC),
        .CHG_CYC    (CCYC),
        .NCONV      (NC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .cont_mode_i  (cont_mode_i),
        .cmp_i        (cmp_i),
        .pi1_o        (pi1_o),
        .pi2_o        (pi2_o),
        .pii1_o       (pii1_o),
        .pii2_o       (pii2_o),
        .pa_o         (pa_o),
        .pb_o         (pb_o),
        .pc_o         (pc_o),
        .pd_o         (pd_o),
        .cmp_p1_o     (cmp_p1_o),
        .cmp_p2_o     (cmp_p2_o),
        .src_n_o      (src_n_o),
        .snk_o        (snk_o),
        .pre_chrg_o   (pre_chrg_o),
        .setup_bias_o (setup_bias_o),
        .busy_o       (busy_o),
        .result_o     (result_o),
        .valid_o      (valid_o)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.sw    = {pi1_o, pi2_o, pii1_o, pii2_o, pa_o, pb_o, pc_o, pd_o};
        o.cp1   = cmp_p1_o;
        o.cp2   = cmp_p2_o;
        o.src_n = src_n_o;
        o.snk   = snk_o;
        o.pre   = pre_chrg_o;
        o.sb    = setup_bias_o;
        o.busy  = busy_o;
        o.valid = valid_o;
        o.res   = result_o;
        return o;
    endfunction

    // Quiescent (idle / reset) outputs given the held result and chop phase
    function automatic obs_t rest_obs(input logic cp1, input logic [RW-1:0] res);
        obs_t o;
        o.sw    = SW_REST;
        o.cp1   = cp1;
        o.cp2   = ~cp1;
        o.src_n = 1'b1;
        o.snk   = 1'b0;
        o.pre   = 1'b0;
        o.sb    = 1'b0;
        o.busy  = 1'b0;
        o.valid = 1'b0;
        o.res   = res;
        return o;
    endfunction

    function automatic logic rnd();
        return 1'($urandom % 2);
    endfunction

    function automatic logic fill(input int mode);
        return (mode == 0) ? 1'b0 : rnd();
    endfunction

    // Conversion decision i within a result: 0 all-zero, 1 all-one, 2 alternating, 3 random
    function automatic logic conv_bit(input int mode, input int i);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'((i + 1) % 2);
            default: return rnd();
        endcase
    endfunction

    task automatic push(input int ph, input logic [7:0] sw, input logic pre, input logic valid,
                        input logic cmpv, input logic cont);
        step_t s;
        if (ph == PH_BLANK) m_cp1 = ~m_cp1;
        if (pend_fall) begin
            m_sb      = 1'b0;
            pend_fall = 1'b0;
        end
        s.o.sw    = sw;
        s.o.cp1   = m_cp1;
        s.o.cp2   = ~m_cp1;
        s.o.src_n = ~pend_src;
        s.o.snk   = pend_snk;
        s.o.pre   = pre;
        s.o.sb    = m_sb;
        s.o.busy  = (ph != PH_IDLE);
        s.o.valid = valid;
        s.o.res   = m_res;
        s.cmp     = cmpv;
        s.cont    = cont;
        s.start   = (ph != PH_IDLE && rnd_start != 0) ? rnd() : 1'b0;
        s.ph      = ph;
        pend_src  = 1'b0;
        pend_snk  = 1'b0;
        tr.push_back(s);
    endtask

    // Build the expected waveform of one start-to-idle run; plan[r] = cont_mode at result r
    task automatic build(input int mode, input logic [3:0] plan);
        int snks, r, acc;
        logic d, b, go;
        tr.delete();
        m_sb = 1'b1;
        pend_src = 1'b0;
        pend_snk = 1'b0;
        pend_fall = 1'b0;
        for (int k = 0; k < int'(PRE); k++) push(PH_PRE, SW_REST, 1'b1, 1'b0, fill(mode), rnd());
        snks = 0;
        while (snks < int'(SITER)) begin
            push(PH_BLANK, SW_OFF, 1'b0, 1'b0, fill(mode), rnd());
            d = (mode == 3) ? rnd() : 1'b0;
            for (int k = 0; k < int'(SCYC); k++)
                push(PH_SETUP, SW_PI, 1'b0, 1'b0, (k == int'(SCYC) - 1) ? d : fill(mode), rnd());
            if (d) begin
                pend_src = 1'b1;
            end else begin
                pend_snk = 1'b1;
                snks++;
                if (snks == int'(SITER)) pend_fall = 1'b1;
            end
        end
        r = 0;
        do begin
            acc = 0;
            for (int i = 0; i < int'(NC); i++) begin
                push(PH_BLANK, SW_OFF, 1'b0, 1'b0, fill(mode), rnd());
                for (int k = 0; k < int'(DCYC); k++)
                    push(PH_DIODE, SW_PII, 1'b0, 1'b0, fill(mode), rnd());
                push(PH_BLANK, SW_OFF, 1'b0, 1'b0, fill(mode), rnd());
                b = conv_bit(mode, i);
                acc += int'(b);
                for (int k = 0; k < int'(BCYC); k++)
                    push(PH_BIG, SW_PI, 1'b0, 1'b0, (k == int'(BCYC) - 1) ? b : fill(mode), rnd());
                push(PH_BLANK, SW_OFF, 1'b0, 1'b0, fill(mode), rnd());
                if (b) pend_src = 1'b1;
                else   pend_snk = 1'b1;
                for (int k = 0; k < int'(CCYC); k++)
                    push(PH_CHG, b ? SW_HI : SW_LO, 1'b0, 1'b0, fill(mode), rnd());
            end
            m_res = RW'(acc);
            go = plan[r];
            push(PH_OUT, SW_REST, 1'b0, 1'b1, fill(mode), go);
            r++;
        end while (go && r < 4);
        for (int k = 0; k < 3; k++) push(PH_IDLE, SW_REST, 1'b0, 1'b0, fill(mode), rnd());
    endtask

    task automatic check(input string tag, input obs_t o, input obs_t e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, o, e);
        end
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            check(tag, sample(), rest_obs(m_cp1, m_res));
        end
    endtask

    // Present start=1 so that the next edge launches the run
    task automatic kick();
        @(posedge clk);
        #1;
        start_i = 1'b1;
        cmp_i   = rnd();
    endtask

    // Walk the expected waveform; optionally fire async reset in a BIGDIODE cycle at/after abort_min
    task automatic exec(input int abort_min);
        bit stop;
        stop = 1'b0;
        valid_at.delete();
        npre = 0;
        aborted = 1'b0;
        for (int c = 0; c < tr.size() && !stop; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("cyc%0d_ph%0d", c, tr[c].ph), sample(), tr[c].o);
            if (valid_o) valid_at.push_back(c);
            if (pre_chrg_o) npre++;
            cmp_i       = tr[c].cmp;
            cont_mode_i = tr[c].cont;
            start_i     = tr[c].start;
            if (abort_min >= 0 && c >= abort_min && tr[c].ph == PH_BIG) begin
                #2;
                reset = 1'b1;
                #1;
                check("rst_async", sample(), rest_obs(1'b0, '0));
                aborted = 1'b1;
                stop = 1'b1;
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start_i = 1'b0;
        cont_mode_i = 1'b0;
        cmp_i = 1'b0;
        rnd_start = 0;
        m_cp1 = 1'b0;
        m_res = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst", sample(), rest_obs(1'b0, '0));
        #3;
        reset = 1'b0;
        idle_cycles("idle", 2);

        // All-zero decisions: 8 setup iterations, result 0
        build(0, 4'b0000);
        kick();
        exec(-1);
        check_int("resA", int'(result_o), 0);

        // All-one conversion decisions, start toggling while busy
        rnd_start = 1;
        build(1, 4'b0000);
        kick();
        exec(-1);
        check_int("resB", int'(result_o), int'(NC));

        // Alternating decisions, continuous mode for three results
        build(2, 4'b0011);
        kick();
        exec(-1);
        check_int("nvalid", valid_at.size(), 3);
        if (valid_at.size() >= 3) begin
            check_int("per0", valid_at[1] - valid_at[0], PERIOD);
            check_int("per1", valid_at[2] - valid_at[1], PERIOD);
        end
        check_int("npre", npre, int'(PRE));
        check_int("resC", int'(result_o), int'((NC + 1) / 2));

        // Random run aborted by reset in a BIGDIODE phase
        build(3, 4'b0000);
        kick();
        exec(200);
        check_int("aborted", int'(aborted), 1);
        start_i = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold", sample(), rest_obs(1'b0, '0));
        end
        start_i = 1'b0;
        #3;
        reset = 1'b0;
        m_cp1 = 1'b0;
        m_res = '0;
        idle_cycles("post_rst", 2);

        // Random run to completion after the abort, two results
        build(3, 4'b0001);
        kick();
        exec(-1);
        check_int("resE", int'(result_o), int'(m_res));
        idle_cycles("end_idle", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
